// File: rtl/lsu_mem_stage_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_if
//   Data-memory bus between the load/store stage and data memory.
//   The master (LSU) raises mem_req and holds mem_we/mem_addr/mem_wdata/
//   mem_wstrb steady until the slave (memory) answers with mem_ready.
//   For reads, mem_rdata is valid in the same cycle as mem_ready.
//
//   Signals:
//     mem_req    master->slave  request, held until accepted
//     mem_we     master->slave  1 = store, 0 = load
//     mem_addr   master->slave  word address (ADDR_W bits)
//     mem_wdata  master->slave  lane-replicated store data
//     mem_wstrb  master->slave  byte enables (0 for loads)
//     mem_ready  slave->master  accept strobe
//     mem_rdata  slave->master  read word
// -----------------------------------------------------------------------------
interface lsu_mem_if #(
  parameter int ADDR_W = 12
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
//   Memory-access stage fed directly by the ALU. The ALU result is the byte
//   effective address of a load/store. Memory ops go to data memory over the
//   lsu_mem_if req/ready bus; loads are lane-extracted and sign/zero extended.
//   Non-memory ops and misaligned accesses complete in one cycle without any
//   memory traffic.
//
//   Ports:
//     clk         clock, all state updates on posedge
//     rst         asynchronous active-high reset
//     start       op valid, sampled only while idle
//     alu_code    6-bit op code (ALU_* encodings)
//     alu_result  effective byte address
//     store_data  rs2 value for stores
//     busy        high whenever the stage is not idle
//     done        one-cycle completion pulse
//     load_data   extended load result while done=1, else 0
//     err         [0] misaligned, [1] timeout; valid while done=1
//     mem         lsu_mem_if master modport (data-memory bus)
//
//   Configuration:
//     LSU_TIMEOUT_EN  when defined, an access that sees no mem_ready for
//                     TIMEOUT_CYCLES cycles is aborted with err[1]=1.
//                     When undefined, ACCESS waits indefinitely.
// -----------------------------------------------------------------------------

`ifndef ALU_ADD
`define ALU_ADD 6'd0
`endif
`ifndef ALU_LB
`define ALU_LB  6'd16
`endif
`ifndef ALU_LH
`define ALU_LH  6'd17
`endif
`ifndef ALU_LW
`define ALU_LW  6'd18
`endif
`ifndef ALU_LBU
`define ALU_LBU 6'd19
`endif
`ifndef ALU_LHU
`define ALU_LHU 6'd20
`endif
`ifndef ALU_SB
`define ALU_SB  6'd24
`endif
`ifndef ALU_SH
`define ALU_SH  6'd25
`endif
`ifndef ALU_SW
`define ALU_SW  6'd26
`endif

module lsu_mem_stage #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  alu_code,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  err,
  lsu_mem_if.master   mem
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Access size encoding shared by the decoder and the load extractor.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state;

  // Attributes of the op currently in ACCESS, captured at start.
  logic [1:0]  op_size;
  logic        op_uns;
  logic        op_store;
  logic [1:0]  op_off;

  logic        dec_mem;
  logic        dec_store;
  logic        dec_uns;
  logic [1:0]  dec_size;
  logic        misaligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] rd_shift;
  logic [31:0] extracted;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Address bits above the data-memory word range never reach memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^alu_result[31:ADDR_W+2];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Classify the incoming op code: memory or not, direction, size, signedness.
  always_comb begin
    dec_mem   = 1'b0;
    dec_store = 1'b0;
    dec_uns   = 1'b0;
    dec_size  = SZ_BYTE;
    case (alu_code)
      `ALU_LB:  dec_mem = 1'b1;
      `ALU_LBU: begin dec_mem = 1'b1; dec_uns = 1'b1; end
      `ALU_LH:  begin dec_mem = 1'b1; dec_size = SZ_HALF; end
      `ALU_LHU: begin dec_mem = 1'b1; dec_size = SZ_HALF; dec_uns = 1'b1; end
      `ALU_LW:  begin dec_mem = 1'b1; dec_size = SZ_WORD; end
      `ALU_SB:  begin dec_mem = 1'b1; dec_store = 1'b1; end
      `ALU_SH:  begin dec_mem = 1'b1; dec_store = 1'b1; dec_size = SZ_HALF; end
      `ALU_SW:  begin dec_mem = 1'b1; dec_store = 1'b1; dec_size = SZ_WORD; end
      default:  ;
    endcase
  end

  // Byte accesses are never misaligned; halves need bit0 clear, words both.
  // Store data is replicated across lanes so memory only needs the strobes.
  always_comb begin
    misaligned = ((dec_size == SZ_HALF) && alu_result[0]) ||
                 ((dec_size == SZ_WORD) && (alu_result[1:0] != 2'b00));
    lane_wdata = 32'h0;
    lane_wstrb = 4'b0000;
    if (dec_store) begin
      case (dec_size)
        SZ_BYTE: begin
          lane_wdata = {4{store_data[7:0]}};
          lane_wstrb = 4'b0001 << alu_result[1:0];
        end
        SZ_HALF: begin
          lane_wdata = {2{store_data[15:0]}};
          lane_wstrb = 4'b0011 << alu_result[1:0];
        end
        default: begin
          lane_wdata = store_data;
          lane_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    rd_shift = mem.mem_rdata >> {op_off, 3'b000};
    case (op_size)
      SZ_BYTE: extracted = op_uns ? {24'h0, rd_shift[7:0]}
                                  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: extracted = op_uns ? {16'h0, rd_shift[15:0]}
                                  : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: extracted = rd_shift;
    endcase
  end

  // Control FSM. mem_req is a flop cleared by the async reset, so an access
  // in flight is abandoned immediately and no done is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      load_data     <= 32'h0;
      err           <= 2'b00;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= 32'h0;
      mem.mem_wstrb <= 4'b0000;
      op_size       <= SZ_BYTE;
      op_uns        <= 1'b0;
      op_store      <= 1'b0;
      op_off        <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (dec_mem && !misaligned) begin
              state         <= ACCESS;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= dec_store;
              mem.mem_addr  <= alu_result[ADDR_W+1:2];
              mem.mem_wdata <= lane_wdata;
              mem.mem_wstrb <= lane_wstrb;
              op_size       <= dec_size;
              op_uns        <= dec_uns;
              op_store      <= dec_store;
              op_off        <= alu_result[1:0];
`ifdef LSU_TIMEOUT_EN
              wait_cnt      <= '0;
`endif
            end else begin
              state     <= DONE;
              load_data <= 32'h0;
              err       <= {1'b0, dec_mem & misaligned};
            end
          end
        end

        ACCESS: begin
          // A ready arriving on the last allowed cycle still completes normally.
          if (mem.mem_ready) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            load_data   <= op_store ? 32'h0 : extracted;
            err         <= 2'b00;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            load_data   <= 32'h0;
            err         <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          state     <= IDLE;
          load_data <= 32'h0;
          err       <= 2'b00;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
//   Self-checking bench for lsu_mem_stage. Each scenario task pushes the
//   expected outcome of every op to a scoreboard queue as it is driven and
//   pops/compares it once the DUT has completed the op.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lsu_mem_stage;

  localparam logic [5:0] C_ADD = 6'd0;
  localparam logic [5:0] C_LB  = 6'd16;
  localparam logic [5:0] C_LH  = 6'd17;
  localparam logic [5:0] C_LW  = 6'd18;
  localparam logic [5:0] C_LBU = 6'd19;
  localparam logic [5:0] C_LHU = 6'd20;
  localparam logic [5:0] C_SB  = 6'd24;
  localparam logic [5:0] C_SH  = 6'd25;
  localparam logic [5:0] C_SW  = 6'd26;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  alu_code;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  err;

  int pass_count  = 0;
  int check_count = 0;

  lsu_mem_if #(.ADDR_W(12)) mem_bus ();

  lsu_mem_stage #(.ADDR_W(12), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alu_code   (alu_code),
    .alu_result (alu_result),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .err        (err),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  code;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ready_after;
    int          req_cycles;
    logic        we;
    logic [11:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] ld;
    logic [1:0]  err;
  } op_t;

  op_t sb[$];

  // What one op looked like on the DUT ports.
  typedef struct {
    int          req_cycles;
    int          done_at;
    int          done_pulses;
    logic        we;
    logic [11:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        stable;
    logic [31:0] ld;
    logic [1:0]  err;
    logic        timed_out;
  } obs_t;

  // Drives one op starting at the current negedge and plays memory: mem_ready
  // is raised on the ready_after-th request cycle (0 = never). Returns at a
  // negedge once done has been seen and the stage is idle again.
  task automatic applyStimulus(input op_t s, input logic poke_busy, output obs_t o);
    o = '{req_cycles: 0, done_at: -1, done_pulses: 0, we: 1'b0, maddr: 12'h0,
          wdata: 32'h0, wstrb: 4'h0, stable: 1'b1, ld: 32'h0, err: 2'b00,
          timed_out: 1'b1};
    start = 1'b1; alu_code = s.code; alu_result = s.addr; store_data = s.sdata;
    @(negedge clk);
    for (int cyc = 0; cyc < 200; cyc++) begin
      start = 1'b0;
      if (mem_bus.mem_req) begin
        if (o.req_cycles == 0) begin
          o.we = mem_bus.mem_we; o.maddr = mem_bus.mem_addr;
          o.wdata = mem_bus.mem_wdata; o.wstrb = mem_bus.mem_wstrb;
        end else if (o.we !== mem_bus.mem_we || o.maddr !== mem_bus.mem_addr ||
                     o.wdata !== mem_bus.mem_wdata || o.wstrb !== mem_bus.mem_wstrb) begin
          o.stable = 1'b0;
        end
        o.req_cycles++;
        if (poke_busy && o.req_cycles == 1) begin
          start = 1'b1; alu_code = C_ADD;
        end
        if (s.ready_after > 0 && o.req_cycles == s.ready_after) begin
          mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = s.rdata;
        end else begin
          mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'h5A5A_5A5A;
        end
      end else begin
        mem_bus.mem_ready = 1'b0;
      end
      if (done) begin
        o.done_pulses++;
        if (o.done_at < 0) begin
          o.done_at = cyc; o.ld = load_data; o.err = err;
        end
      end else if (o.done_pulses > 0 && !busy) begin
        o.timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mem_bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; alu_code = C_ADD; alu_result = 32'h0; store_data = 32'h0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_count++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else pass_count++;
    check_count++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else pass_count++;
    check_count++; if (mem_bus.mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req got %b want 0", mem_bus.mem_req); else pass_count++;
    check_count++; if (mem_bus.mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we got %b want 0", mem_bus.mem_we); else pass_count++;
    check_count++; if (load_data !== 32'h0) $display("[TB] FAIL reset_load_data got %h want 0", load_data); else pass_count++;
    check_count++; if (err !== 2'b00) $display("[TB] FAIL reset_err got %b want 00", err); else pass_count++;
    check_count++; if (mem_bus.mem_addr !== 12'h0) $display("[TB] FAIL reset_mem_addr got %h want 0", mem_bus.mem_addr); else pass_count++;
    check_count++; if (mem_bus.mem_wdata !== 32'h0) $display("[TB] FAIL reset_mem_wdata got %h want 0", mem_bus.mem_wdata); else pass_count++;
    check_count++; if (mem_bus.mem_wstrb !== 4'h0) $display("[TB] FAIL reset_mem_wstrb got %b want 0", mem_bus.mem_wstrb); else pass_count++;
    rst = 1'b0;
    @(negedge clk);
    check_count++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL post_reset_idle got busy=%b done=%b want 0/0", busy, done); else pass_count++;
  endtask

  // Runs a table of ops, pushing each expectation as it is driven and
  // comparing the popped expectation against what the DUT produced.
  task automatic test_ops(input string tag, input op_t tbl[]);
    obs_t o;
    op_t  e;
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      applyStimulus(tbl[i], 1'b0, o);
      e = sb.pop_front();
      check_count++; if (o.timed_out) $display("[TB] FAIL %s[%0d] completion got none want done", tag, i); else pass_count++;
      check_count++; if (o.req_cycles !== e.req_cycles) $display("[TB] FAIL %s[%0d] req_cycles got %0d want %0d", tag, i, o.req_cycles, e.req_cycles); else pass_count++;
      check_count++; if (o.done_pulses !== 1) $display("[TB] FAIL %s[%0d] done_pulses got %0d want 1", tag, i, o.done_pulses); else pass_count++;
      check_count++; if (o.done_at !== e.req_cycles) $display("[TB] FAIL %s[%0d] done_latency got %0d want %0d", tag, i, o.done_at, e.req_cycles); else pass_count++;
      check_count++; if (o.ld !== e.ld) $display("[TB] FAIL %s[%0d] load_data got %h want %h", tag, i, o.ld, e.ld); else pass_count++;
      check_count++; if (o.err !== e.err) $display("[TB] FAIL %s[%0d] err got %b want %b", tag, i, o.err, e.err); else pass_count++;
      if (e.req_cycles > 0) begin
        check_count++; if (o.we !== e.we) $display("[TB] FAIL %s[%0d] mem_we got %b want %b", tag, i, o.we, e.we); else pass_count++;
        check_count++; if (o.maddr !== e.maddr) $display("[TB] FAIL %s[%0d] mem_addr got %h want %h", tag, i, o.maddr, e.maddr); else pass_count++;
        check_count++; if (o.wstrb !== e.wstrb) $display("[TB] FAIL %s[%0d] mem_wstrb got %b want %b", tag, i, o.wstrb, e.wstrb); else pass_count++;
        check_count++; if (o.stable !== 1'b1) $display("[TB] FAIL %s[%0d] bus_stable got %b want 1", tag, i, o.stable); else pass_count++;
        if (e.we) begin
          check_count++; if (o.wdata !== e.wdata) $display("[TB] FAIL %s[%0d] mem_wdata got %h want %h", tag, i, o.wdata, e.wdata); else pass_count++;
        end
      end
    end
  endtask

  task automatic test_loads;
    op_t tbl[] = '{
      '{C_LW,  32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, 3, 1'b0, 12'h004, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00},
      '{C_LB,  32'h0000_0013, 32'h0, 32'h8000_0000, 1, 1, 1'b0, 12'h004, 32'h0, 4'h0, 32'hFFFF_FF80, 2'b00},
      '{C_LBU, 32'h0000_0013, 32'h0, 32'h8000_0000, 2, 2, 1'b0, 12'h004, 32'h0, 4'h0, 32'h0000_0080, 2'b00},
      '{C_LHU, 32'h0000_0012, 32'h0, 32'hABCD_0000, 1, 1, 1'b0, 12'h004, 32'h0, 4'h0, 32'h0000_ABCD, 2'b00},
      '{C_LH,  32'h0000_0012, 32'h0, 32'h8001_0000, 1, 1, 1'b0, 12'h004, 32'h0, 4'h0, 32'hFFFF_8001, 2'b00},
      '{C_LH,  32'h0000_0010, 32'h0, 32'h0000_7FFF, 1, 1, 1'b0, 12'h004, 32'h0, 4'h0, 32'h0000_7FFF, 2'b00},
      '{C_LB,  32'h0000_0011, 32'h0, 32'h0000_F100, 1, 1, 1'b0, 12'h004, 32'h0, 4'h0, 32'hFFFF_FFF1, 2'b00},
      '{C_LW,  32'h0000_FFFC, 32'h0, 32'h1234_5678, 1, 1, 1'b0, 12'hFFF, 32'h0, 4'h0, 32'h1234_5678, 2'b00}
    };
    test_ops("load", tbl);
  endtask

  task automatic test_stores;
    op_t tbl[] = '{
      '{C_SB, 32'h0000_0006, 32'h1234_56A5, 32'h0,         2, 2, 1'b1, 12'h001, 32'hA5A5_A5A5, 4'b0100, 32'h0, 2'b00},
      '{C_SH, 32'h0000_0002, 32'h1234_56A5, 32'h0,         1, 1, 1'b1, 12'h000, 32'h56A5_56A5, 4'b1100, 32'h0, 2'b00},
      '{C_SW, 32'h0000_000C, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 1, 1'b1, 12'h003, 32'hCAFE_F00D, 4'b1111, 32'h0, 2'b00},
      '{C_SB, 32'h0000_0003, 32'h0000_0042, 32'hFFFF_FFFF, 1, 1, 1'b1, 12'h000, 32'h4242_4242, 4'b1000, 32'h0, 2'b00}
    };
    test_ops("store", tbl);
  endtask

  task automatic test_no_access;
    op_t tbl[] = '{
      '{C_LW,  32'h0000_0006, 32'h0,         32'h0, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0, 2'b01},
      '{C_LH,  32'h0000_0013, 32'h0,         32'h0, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0, 2'b01},
      '{C_SW,  32'h0000_0002, 32'h1111_1111, 32'h0, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0, 2'b01},
      '{C_SH,  32'h0000_0001, 32'h2222_2222, 32'h0, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0, 2'b01},
      '{C_ADD, 32'h0000_0013, 32'h0,         32'h0, 1, 0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0, 2'b00}
    };
    test_ops("noacc", tbl);
    // mem_ready while idle must not start anything.
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check_count++; if (busy !== 1'b0 || done !== 1'b0 || mem_bus.mem_req !== 1'b0)
      $display("[TB] FAIL idle_ready_ignored got busy=%b done=%b req=%b want 0/0/0", busy, done, mem_bus.mem_req);
    else pass_count++;
    mem_bus.mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    op_t tbl[] = '{
      '{C_SW,  32'h0000_0020, 32'h0BAD_F00D, 32'h0,         1, 1, 1'b1, 12'h008, 32'h0BAD_F00D, 4'b1111, 32'h0,         2'b00},
      '{C_LHU, 32'h0000_0022, 32'h0,         32'h0BAD_F00D, 1, 1, 1'b0, 12'h008, 32'h0,         4'h0,    32'h0000_0BAD, 2'b00},
      '{C_ADD, 32'h0000_0000, 32'h0,         32'h0,         1, 0, 1'b0, 12'h0,   32'h0,         4'h0,    32'h0,         2'b00},
      '{C_LBU, 32'h0000_0021, 32'h0,         32'h0BAD_F00D, 2, 2, 1'b0, 12'h008, 32'h0,         4'h0,    32'h0000_00F0, 2'b00}
    };
    test_ops("b2b", tbl);
  endtask

  task automatic test_busy_start;
    obs_t o;
    op_t  e;
    int   extra;
    op_t  s = '{C_LW, 32'h0000_0040, 32'h0, 32'h7777_0001, 3, 3, 1'b0, 12'h010, 32'h0, 4'h0, 32'h7777_0001, 2'b00};
    sb.push_back(s);
    applyStimulus(s, 1'b1, o);
    e = sb.pop_front();
    check_count++; if (o.ld !== e.ld || o.done_pulses !== 1) $display("[TB] FAIL busy_start_op got ld=%h pulses=%0d want ld=%h pulses=1", o.ld, o.done_pulses, e.ld); else pass_count++;
    extra = 0;
    repeat (4) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    check_count++; if (extra !== 0) $display("[TB] FAIL busy_start_ignored got %0d active cycles want 0", extra); else pass_count++;
  endtask

  task automatic test_reset_mid_access;
    int seen;
    start = 1'b1; alu_code = C_LW; alu_result = 32'h0000_0080; store_data = 32'h0;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_count++; if (mem_bus.mem_req !== 1'b1) $display("[TB] FAIL pre_reset_req got %b want 1", mem_bus.mem_req); else pass_count++;
    #2 rst = 1'b1;
    #1;
    check_count++; if (mem_bus.mem_req !== 1'b0) $display("[TB] FAIL async_reset_req got %b want 0", mem_bus.mem_req); else pass_count++;
    check_count++; if (busy !== 1'b0) $display("[TB] FAIL async_reset_busy got %b want 0", busy); else pass_count++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || mem_bus.mem_req) seen++;
    end
    check_count++; if (seen !== 0) $display("[TB] FAIL abandoned_access got %0d active cycles want 0", seen); else pass_count++;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    op_t tbl[] = '{
      '{C_LW, 32'h0000_0100, 32'h0, 32'h0,         0, 4, 1'b0, 12'h040, 32'h0, 4'h0, 32'h0,         2'b10},
      '{C_LW, 32'h0000_0100, 32'h0, 32'hC0DE_0004, 4, 4, 1'b0, 12'h040, 32'h0, 4'h0, 32'hC0DE_0004, 2'b00}
    };
    test_ops("timeout", tbl);
  endtask
`endif

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_no_access;
    test_back_to_back;
    test_busy_start;
    test_reset_mid_access;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
